pipe_skid_stage: RTL and testbench
==================================

// Module: pipe_skid_stage
// PURPOSE
//  Generic, parametrised inter-stage pipeline register for the riscv64i pipeline.
//  Replaces the fixed per-stage "always latch" registers (IF/ID ... MEM/WB).
//  Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under
//  back-pressure, and a synchronous flush.
//  Each stage instantiates it with its own packed payload struct width.
// PARAMETERS
//  WIDTH      64  payload width in bits (set to $bits(<stage>_Pipe_t))
//  RST_VAL    '0  payload value loaded on reset; width WIDTH
//  CNT_WIDTH  32  width of the statistics counters (only with PIPE_STAT_EN)
// PORTS
//  clk_i         in   1          clock; all state updates on posedge
//  rst_i         in   1          reset; asynchronous, active-high
//  in_valid_i    in   1          upstream payload valid
//  in_ready_o    out  1          stage can accept; registered, not combinational
//  in_data_i     in   WIDTH      upstream payload
//  out_valid_o   out  1          downstream payload valid
//  out_ready_i   in   1          downstream accepts
//  out_data_o    out  WIDTH      downstream payload
//  flush_i       in   1          kill all held entries (branch mispredict/trap)
//  stall_cnt_o   out  CNT_WIDTH  cycles with out_valid_o & ~out_ready_i [PIPE_STAT_EN]
//  flush_cnt_o   out  CNT_WIDTH  flush_i cycles that killed >=1 valid entry [PIPE_STAT_EN]
// BEHAVIOUR
//  - Reset (async, rst_i=1):
//    - state=EMPTY; out_valid_o=0; in_ready_o=1.
//    - out_data_o=RST_VAL; skid=RST_VAL.
//    - Counters=0.
//    - Reset mid-transfer discards both entries immediately.
//  - in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
//  - Registers: main (drives out_data_o) and skid.
//  - in_ready_o = (state != FULL); out_valid_o = (state != EMPTY).
//  - FSM {EMPTY, BUSY, FULL}:
//    - EMPTY: in_fire -> BUSY, main<=in.
//    - BUSY: in_fire&out_fire -> BUSY, main<=in.
//    - BUSY: in_fire&~out_fire -> FULL, skid<=in.
//    - BUSY: ~in_fire&out_fire -> EMPTY.
//    - FULL: out_fire -> BUSY, main<=skid (in_fire impossible).
//  - Latency: input accepted at edge N appears on out_data_o after edge N (1 cycle).
//    Throughput is 1 payload/cycle while out_ready_i=1.
//  - Ordering is strict FIFO; no payload is duplicated or lost except by flush.
//  - in_valid_i while in_ready_o=0 is ignored; upstream holds data and valid.
//  - Payload bits of an invalid slot are don't-care, but are not modified
//    except by a load.
//  - flush_i=1 (synchronous): next state=EMPTY, out_valid_o=0 after the edge.
//    - Flush overrides a same-cycle in_fire: the input is dropped, yet upstream
//      sees it as accepted.
//    - A same-cycle out_fire still completes (downstream consumed it).
//  - Back-to-back flushes are legal; a flush in EMPTY is a no-op.
// CONFIGURATION
//  - Macro PIPE_STAT_EN defined:
//    - stall_cnt_o and flush_cnt_o are implemented.
//    - Saturating counters: hold at all-ones, no wrap.
//    - Cleared only by reset.
//  - Macro PIPE_STAT_EN undefined:
//    - Both ports are still present and tied to '0.
//    - No counter flops are synthesised.
//    - Handshake behaviour is identical.
// STRUCTURE
//  - pipeline_pkg:
//    - add typedef enum logic [1:0] {SKID_EMPTY, SKID_BUSY, SKID_FULL} skid_state_e.
//    - add localparam int PIPE_CNT_WIDTH = 32.
//    - add the per-stage payload structs used to size WIDTH.
//  - Sub-module pipe_sat_counter:
//    - parameter CNT_WIDTH; inputs clk_i, rst_i, inc_i; output cnt_o.
//    - Instantiated twice under `ifdef PIPE_STAT_EN.
// TESTING
//  1. Reset:
//     - Stimulus: assert rst_i asynchronously mid-cycle with FULL state.
//     - Response: out_valid_o=0 and in_ready_o=1 before the next edge;
//       out_data_o=RST_VAL.
//  2. Streaming:
//     - Stimulus: in_valid_i=1 with data 1..8, out_ready_i=1 throughout.
//     - Response: out_data_o 1..8 on consecutive cycles, 1-cycle latency,
//       in_ready_o never drops.
//  3. Back-pressure:
//     - Stimulus: stream 0xA,0xB,0xC; out_ready_i=0 at 0xA's first output cycle.
//     - Response: FULL holds A (main) and B (skid), in_ready_o=0, C held upstream.
//     - Then raise out_ready_i: A,B,C emerge in order, none lost or duplicated.
//  4. Flush:
//     - Stimulus: state FULL; flush_i=1 with in_valid_i=1, data 0xDEAD.
//     - Response: next cycle out_valid_o=0, in_ready_o=1; 0xDEAD never appears.
//  5. Flush with drain:
//     - Stimulus: state BUSY holding 0x5; flush_i=1 and out_ready_i=1 in the same cycle.
//     - Response: 0x5 is consumed that cycle; next cycle EMPTY.
//  6. Counters (PIPE_STAT_EN):
//     - Stimulus: 3 stall cycles, then 2 flushes of valid data, then 1 flush
//       in EMPTY; CNT_WIDTH=2 with 5 stalls.
//     - Response: stall_cnt_o=3, flush_cnt_o=2; with CNT_WIDTH=2, stall_cnt_o
//       saturates at 3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: skid-stage FSM encoding, counter width default and per-stage payloads.
package pipeline_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  localparam int PIPE_CNT_WIDTH = 32;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } if_id_pipe_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [9:0]  ctrl;
  } id_ex_pipe_t;

  typedef struct packed {
    logic [63:0] alu_res;
    logic [63:0] store_val;
    logic [4:0]  rd;
    logic [5:0]  ctrl;
  } ex_mem_pipe_t;

  typedef struct packed {
    logic [63:0] wb_val;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_pipe_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts inc_i cycles, holds at all-ones, cleared only by reset.
module pipe_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with 2-entry skid (1-cycle latency, full rate, registered ready)
// and synchronous flush; stall/flush statistics counters exist only with PIPE_STAT_EN.
module pipe_skid_stage
  import pipeline_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter int               CNT_WIDTH = PIPE_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_data_o,
  input  logic                 flush_i,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_ready_o  = (state_q != SKID_FULL);
  assign out_valid_o = (state_q != SKID_EMPTY);
  assign out_data_o  = main_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_d = SKID_BUSY;
          main_d  = in_data_i;
        end
      end
      SKID_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data_i;
        end else if (in_fire) begin
          state_d = SKID_FULL;
          skid_d  = in_data_i;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          state_d = SKID_BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Flush drops any incoming or shifting payload; slot contents stay untouched.
    if (flush_i) begin
      state_d = SKID_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SKID_EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAT_EN
  logic stall_inc, flush_inc;

  assign stall_inc = out_valid_o & ~out_ready_i;
  // A held entry is killed unless it is the one being consumed this cycle.
  assign flush_inc = flush_i & ((state_q == SKID_FULL) |
                                ((state_q == SKID_BUSY) & ~out_ready_i));

  pipe_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_skid_stage;

  localparam int           W   = 16;
  localparam logic [W-1:0] RV  = 16'h5A5A;
  localparam int           CW  = 8;
  localparam int           CW2 = 2;
`ifdef PIPE_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b0;
  logic           in_valid_i = 1'b0;
  logic           out_ready_i = 1'b0;
  logic           flush_i = 1'b0;
  logic [W-1:0]   in_data_i = '0;
  logic           in_ready_o, out_valid_o, in_ready2, out_valid2;
  logic [W-1:0]   out_data_o, out_data2;
  logic [CW-1:0]  stall_cnt_o, flush_cnt_o;
  logic [CW2-1:0] stall2, flush2;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mq[$];
  int m_stall = 0;
  int m_flush = 0;
  bit dead_seen = 1'b0;

  always #5 clk_i = ~clk_i;

  pipe_skid_stage #(.WIDTH(W), .RST_VAL(RV), .CNT_WIDTH(CW)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .flush_i(flush_i), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipe_skid_stage #(.WIDTH(W), .RST_VAL(RV), .CNT_WIDTH(CW2)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready2), .in_data_i(in_data_i),
    .out_valid_o(out_valid2), .out_ready_i(out_ready_i), .out_data_o(out_data2),
    .flush_i(flush_i), .stall_cnt_o(stall2), .flush_cnt_o(flush2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    d = W'($urandom);
    while (d == 16'hDEAD) d = W'($urandom);
    return d;
  endfunction

  // Reference model: the stage is a FIFO of at most two payloads.
  initial forever begin
    bit inf, outf;
    int killed;
    @(posedge clk_i or posedge rst_i);
    if (rst_i) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      inf    = in_valid_i && (mq.size() < 2);
      outf   = (mq.size() > 0) && out_ready_i;
      if ((mq.size() > 0) && !out_ready_i) m_stall++;
      killed = mq.size() - (outf ? 1 : 0);
      if (outf) void'(mq.pop_front());
      if (flush_i) begin
        if (killed > 0) m_flush++;
        mq.delete();
      end else if (inf) begin
        mq.push_back(in_data_i);
      end
    end
  end

  initial forever begin
    @(negedge clk_i);
    chk("out_valid", out_valid_o, mq.size() > 0);
    chk("in_ready", in_ready_o, mq.size() < 2);
    if (mq.size() > 0) chk("out_data", out_data_o, mq[0]);
    chk("out_valid2", out_valid2, mq.size() > 0);
    chk("stall_cnt", stall_cnt_o, STAT ? sat(m_stall, CW) : 0);
    chk("flush_cnt", flush_cnt_o, STAT ? sat(m_flush, CW) : 0);
    chk("stall_cnt2", stall2, STAT ? sat(m_stall, CW2) : 0);
    chk("flush_cnt2", flush2, STAT ? sat(m_flush, CW2) : 0);
    if (out_valid_o && out_data_o == 16'hDEAD) dead_seen = 1'b1;
  end

  initial begin
    bit acc;
    #2 rst_i = 1'b1;
    #1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_data", out_data_o, RV);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    step();
    step();
    rst_i = 1'b0;

    // Streaming at full rate
    out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = W'(i);
      step();
      chk("stream_valid", out_valid_o, 1);
      chk("stream_data", out_data_o, i);
      chk("stream_ready", in_ready_o, 1);
    end
    in_valid_i = 1'b0;
    step();
    chk("stream_drained", out_valid_o, 0);

    // Back-pressure into the skid slot
    in_valid_i = 1'b1; in_data_i = 16'h000A; out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0; in_data_i = 16'h000B;
    step();
    chk("bp_full_ready", in_ready_o, 0);
    chk("bp_full_data", out_data_o, 16'h000A);
    in_data_i = 16'h000C;
    step();
    chk("bp_hold_ready", in_ready_o, 0);
    chk("bp_hold_data", out_data_o, 16'h000A);
    out_ready_i = 1'b1;
    step();
    chk("bp_out_b", out_data_o, 16'h000B);
    chk("bp_ready_back", in_ready_o, 1);
    step();
    chk("bp_out_c", out_data_o, 16'h000C);
    in_valid_i = 1'b0;
    step();
    chk("bp_drained", out_valid_o, 0);

    // Flush while full, with a same-cycle input that must be dropped
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 16'h0001;
    step();
    in_data_i = 16'h0002;
    step();
    chk("fl_full", in_ready_o, 0);
    in_data_i = 16'hDEAD; flush_i = 1'b1;
    step();
    chk("fl_valid", out_valid_o, 0);
    chk("fl_ready", in_ready_o, 1);
    flush_i = 1'b0; in_valid_i = 1'b0;
    step();
    chk("fl_still_empty", out_valid_o, 0);

    // Flush with same-cycle drain
    in_valid_i = 1'b1; in_data_i = 16'h0005;
    step();
    chk("fd_busy_data", out_data_o, 16'h0005);
    in_valid_i = 1'b0; flush_i = 1'b1; out_ready_i = 1'b1;
    step();
    chk("fd_empty", out_valid_o, 0);
    flush_i = 1'b0;

    // Asynchronous reset mid-cycle while full
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 16'h0011;
    step();
    in_data_i = 16'h0022;
    step();
    in_valid_i = 1'b0;
    chk("ar_full", in_ready_o, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("ar_out_valid", out_valid_o, 0);
    chk("ar_in_ready", in_ready_o, 1);
    chk("ar_out_data", out_data_o, RV);
    step();
    rst_i = 1'b0;

    // Counter sequence from a clean reset
    in_valid_i = 1'b1; in_data_i = 16'h0001; out_ready_i = 1'b0;
    step();
    in_data_i = 16'h0002;
    step();
    in_valid_i = 1'b0;
    step();
    flush_i = 1'b1; out_ready_i = 1'b1;
    step();
    flush_i = 1'b0; in_valid_i = 1'b1; in_data_i = 16'h0003; out_ready_i = 1'b0;
    step();
    in_data_i = 16'h0004;
    step();
    in_valid_i = 1'b0; flush_i = 1'b1; out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    step();
    flush_i = 1'b0;
    chk("cnt_stall_3", stall_cnt_o, STAT ? 3 : 0);
    chk("cnt_flush_2", flush_cnt_o, STAT ? 2 : 0);
    chk("cnt2_flush_2", flush2, STAT ? 2 : 0);
    in_valid_i = 1'b1; in_data_i = 16'h0006;
    step();
    in_valid_i = 1'b0;
    step();
    step();
    chk("cnt_stall_5", stall_cnt_o, STAT ? 5 : 0);
    chk("cnt2_stall_sat", stall2, STAT ? 3 : 0);
    out_ready_i = 1'b1;
    step();

    // Randomized traffic; upstream holds an unaccepted offer
    acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!(in_valid_i && !acc)) begin
        in_valid_i = ($urandom_range(0, 99) < 60);
        in_data_i  = rand_data();
      end
      out_ready_i = ($urandom_range(0, 99) < 65);
      flush_i     = ($urandom_range(0, 99) < 4);
      acc = in_valid_i && in_ready_o;
      step();
    end
    in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    step();
    step();
    chk("final_empty", out_valid_o, 0);
    chk("dead_never_seen", dead_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
